load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage load/store unit for the RV32I pipeline. It sits between the EX/MEM pipeline register and the data-memory bus.
- Accepts one load or store per MEM-stage instruction and stalls the pipeline while the access is in flight.
- Generates byte enables and write-lane replication, and sign- or zero-extends load data.
- Decodes the LED MMIO register locally and flags misaligned or illegal accesses.

Parameters:
- XLEN, 32, data width.
- ALEN, 32, address width.
- LED_WIDTH, 4, width of the LED MMIO register.
- LED_ADDR, MMIO_LED_ADDR (32'hFFFF_FFF0), address of the LED register.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  MEM stage holds a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  funct3_mem_t access size and sign.
- req_addr  in  ALEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- lsu_stall  out  1  pipeline hold request.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load result; valid with resp_valid.
- lsu_fault  out  1  misaligned or illegal access; pulses with resp_valid.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  ALEN  word-aligned address, with [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated write data.
- mem_gnt  in  1  bus accepted the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read word.
- leds  out  LED_WIDTH  LED register.

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE.
  - All outputs are 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, lsu_fault, leds.
  - Reset mid-transaction drops mem_req the next cycle and discards the pending request.
- lsu_stall = req_valid && state != DONE (combinational). The pipeline holds req_* stable while lsu_stall is 1.
- States: IDLE, REQ, WAIT, DONE (lsu_state_t).
- IDLE with req_valid: the request is registered and the next state is chosen in this priority order:
  - Illegal funct3 (011, 110, 111), half access with addr[0] = 1, or word access with addr[1:0] != 0 → DONE, lsu_fault = 1, resp_rdata = 0. No bus activity and no LED write.
  - Word-aligned address == LED_ADDR → DONE:
    - A store writes leds <= req_wdata[LED_WIDTH-1:0] for any size.
    - A load returns zero-extended leds.
    - No bus activity.
  - Otherwise → REQ.
- REQ:
  - Drives mem_req = 1 plus the registered mem_we, mem_addr, mem_be and mem_wdata, all held stable until mem_gnt.
  - On mem_gnt: a store goes to DONE, a load goes to WAIT.
  - mem_req deasserts the cycle after the grant.
- WAIT:
  - mem_rvalid is legal no earlier than the cycle after the grant; mem_rvalid in REQ is ignored.
  - On mem_rvalid, resp_rdata <= extend(mem_rdata >> 8*addr[1:0]) and the next state is DONE.
  - Wait is unbounded (no timeout).
- DONE: resp_valid = 1 for exactly one cycle, lsu_stall = 0, then always IDLE. A new request is seen in the following IDLE cycle.
- Byte lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = 4'b0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
  - mem_we = 0 for loads; be still reflects the access size.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Latency:
  - Store with grant on the first REQ cycle: stall for 2 cycles, resp_valid on cycle 3.
  - Load with grant then rvalid on consecutive cycles: resp_valid on cycle 4.
  - MMIO and fault accesses: resp_valid on cycle 2.

Decomposition:
- riscv_pkg gains lsu_state_t {IDLE, REQ, WAIT, DONE} and a constant MEM_BE_W = XLEN/8.
- Existing package items used: MMIO_LED_ADDR, LED_WIDTH, funct3_mem_t.
- One combinational sub-module, lsu_align:
  - Store side: addr[1:0], funct3 and wdata → be and lane-replicated wdata.
  - Load side: addr[1:0], funct3 and rdata → extended result.
  - Also produces the misaligned/illegal flag.

Test Plan:
- SB to 0x103, data 0x000000A5, gnt on the first REQ cycle → mem_addr = 0x100, mem_be = 1000, mem_wdata = 0xA5A5A5A5; resp_valid on cycle 3; lsu_fault = 0.
- LB then LBU from 0x102, mem_rdata = 0x0080FF00 → resp_rdata = 0xFFFFFF80, then 0x00000080.
- LW from 0x200 with gnt delayed 3 cycles and rvalid 2 cycles after gnt → mem_req held 4 cycles with stable addr; single resp_valid; lsu_stall deasserts exactly in the DONE cycle.
- SW 0x0000000B to 0xFFFFFFF0, then LW from the same address → leds = 4'hB with mem_req never asserted; load returns 0x0000000B.
- SH to 0x101 and LW from 0x102 → lsu_fault = 1 with resp_valid on cycle 2; no mem_req; leds unchanged.
- rst asserted while in WAIT → next cycle state IDLE, mem_req = 0, leds = 0; a later rvalid produces no resp_valid.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: data sizes, MMIO map, memory funct3 encodings and LSU state.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int LED_WIDTH = 4;
    localparam int MEM_BE_W  = XLEN / 8;

    localparam logic [31:0] MMIO_LED_ADDR = 32'hFFFF_FFF0;

    // Loads and stores share these encodings (SB/SH/SW = LB/LH/LW).
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } funct3_mem_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU: store byte enables and replication,
// load shift and extension, plus the misaligned/illegal access flag.
module lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [1:0]          st_addr_lo,
    input  logic [2:0]          st_funct3,
    input  logic [XLEN-1:0]     st_wdata,
    output logic [MEM_BE_W-1:0] st_be,
    output logic [XLEN-1:0]     st_lane_wdata,
    output logic                st_fault,
    input  logic [1:0]          ld_addr_lo,
    input  logic [2:0]          ld_funct3,
    input  logic [XLEN-1:0]     ld_rdata,
    output logic [XLEN-1:0]     ld_result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        st_fault = 1'b0;
        case (st_funct3)
            MEM_B, MEM_BU: st_fault = 1'b0;
            MEM_H, MEM_HU: st_fault = st_addr_lo[0];
            MEM_W:         st_fault = |st_addr_lo;
            default:       st_fault = 1'b1;
        endcase
    end

    // Size lives in funct3[1:0]; the sign bit does not affect lanes.
    always_comb begin
        st_be         = '0;
        st_lane_wdata = st_wdata;
        case (st_funct3[1:0])
            2'b00: begin
                st_be         = MEM_BE_W'(1) << st_addr_lo;
                st_lane_wdata = {(XLEN/8){st_wdata[7:0]}};
            end
            2'b01: begin
                st_be         = MEM_BE_W'(3) << st_addr_lo;
                st_lane_wdata = {(XLEN/16){st_wdata[15:0]}};
            end
            2'b10: begin
                st_be         = '1;
                st_lane_wdata = st_wdata;
            end
            default: begin
                st_be         = '0;
                st_lane_wdata = st_wdata;
            end
        endcase
    end

    assign shifted = ld_rdata >> {ld_addr_lo, 3'b000};

    always_comb begin
        ld_result = shifted;
        case (ld_funct3)
            MEM_B:   ld_result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MEM_H:   ld_result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MEM_BU:  ld_result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            MEM_HU:  ld_result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: ld_result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one bus access per request, LED MMIO decoded locally,
// faults and MMIO complete without touching the bus.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int               XLEN      = riscv_pkg::XLEN,
    parameter int               ALEN      = 32,
    parameter int               LED_WIDTH = riscv_pkg::LED_WIDTH,
    parameter logic [ALEN-1:0]  LED_ADDR  = MMIO_LED_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ALEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 lsu_stall,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 lsu_fault,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ALEN-1:0]      mem_addr,
    output logic [MEM_BE_W-1:0]  mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic [LED_WIDTH-1:0] leds
);

    lsu_state_t          state;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [1:0]          addr_lo_q;

    logic [MEM_BE_W-1:0] st_be;
    logic [XLEN-1:0]     st_lane_wdata;
    logic                st_fault;
    logic [XLEN-1:0]     ld_result;
    logic                led_hit;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_addr_lo    (req_addr[1:0]),
        .st_funct3     (req_funct3),
        .st_wdata      (req_wdata),
        .st_be         (st_be),
        .st_lane_wdata (st_lane_wdata),
        .st_fault      (st_fault),
        .ld_addr_lo    (addr_lo_q),
        .ld_funct3     (funct3_q),
        .ld_rdata      (mem_rdata),
        .ld_result     (ld_result)
    );

    assign led_hit   = ({req_addr[ALEN-1:2], 2'b00} == LED_ADDR);
    assign lsu_stall = req_valid && (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            lsu_fault  <= 1'b0;
            leds       <= '0;
        end else begin
            resp_valid <= 1'b0;
            lsu_fault  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        if (st_fault) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            lsu_fault  <= 1'b1;
                            resp_rdata <= '0;
                        end else if (led_hit) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            if (req_we) begin
                                leds       <= req_wdata[LED_WIDTH-1:0];
                                resp_rdata <= '0;
                            end else begin
                                resp_rdata <= XLEN'(leds);
                            end
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ALEN-1:2], 2'b00};
                            mem_be    <= st_be;
                            mem_wdata <= st_lane_wdata;
                        end
                    end
                end
                REQ: begin
                    // rvalid here would precede the grant and is ignored.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (we_q) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_result;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        lsu_stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        lsu_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [3:0]  leds;

    int tests_run = 0;
    int failures  = 0;

    load_store_unit #(
        .XLEN      (32),
        .ALEN      (32),
        .LED_WIDTH (4),
        .LED_ADDR  (32'hFFFF_FFF0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .lsu_stall  (lsu_stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .lsu_fault  (lsu_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .leds       (leds)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic release_req();
        req_valid = 1'b0;
        mem_gnt   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // Load with grant on the first REQ cycle and rvalid on the next.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [3:0] exp_be, input logic [31:0] rdata,
                           input logic [31:0] exp_rdata);
        issue(1'b0, f3, addr, 32'h0);
        tick();
        check({tag, "_req"}, {31'b0, mem_req}, 32'd1);
        check({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check({tag, "_wait_req"}, {31'b0, mem_req}, 32'd0);
        check({tag, "_wait_stall"}, {31'b0, lsu_stall}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_done_stall"}, {31'b0, lsu_stall}, 32'd0);
        release_req();
        tick();
        check({tag, "_pulse_end"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        release_req();
        req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0; mem_rdata = '0;
        tick();
        tick();
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp", {30'b0, resp_valid, lsu_fault}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_leds", {28'b0, leds}, 32'd0);
        rst = 1'b0;
        tick();

        // SB to 0x103: lane 3, byte replicated, resp on cycle 3.
        issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
        #1;
        check("sb_stall_c1", {31'b0, lsu_stall}, 32'd1);
        check("sb_resp_c1", {31'b0, resp_valid}, 32'd0);
        tick();
        check("sb_req", {31'b0, mem_req}, 32'd1);
        check("sb_we", {31'b0, mem_we}, 32'd1);
        check("sb_addr", mem_addr, 32'h0000_0100);
        check("sb_be", {28'b0, mem_be}, 32'b1000);
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_stall_c2", {31'b0, lsu_stall}, 32'd1);
        check("sb_resp_c2", {31'b0, resp_valid}, 32'd0);
        mem_gnt = 1'b1;
        tick();
        check("sb_resp_c3", {31'b0, resp_valid}, 32'd1);
        check("sb_fault", {31'b0, lsu_fault}, 32'd0);
        check("sb_stall_c3", {31'b0, lsu_stall}, 32'd0);
        check("sb_req_drop", {31'b0, mem_req}, 32'd0);
        release_req();
        tick();
        check("sb_pulse_end", {31'b0, resp_valid}, 32'd0);

        // SH to 0x102: upper half lanes.
        issue(1'b1, 3'b001, 32'h0000_0102, 32'hDEAD_BEEF);
        tick();
        check("sh_be", {28'b0, mem_be}, 32'b1100);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        mem_gnt = 1'b1;
        tick();
        check("sh_resp", {30'b0, resp_valid, lsu_fault}, 32'b10);
        release_req();
        tick();

        do_load("lb", 3'b000, 32'h0000_0102, 4'b0100, 32'h0080_FF00, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_0102, 4'b0100, 32'h0080_FF00, 32'h0000_0080);
        do_load("lh", 3'b001, 32'h0000_0100, 4'b0011, 32'h1234_8001, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h0000_0102, 4'b1100, 32'h8001_7FFF, 32'h0000_8001);

        // LW 0x200: grant on the 4th REQ cycle, rvalid 2 cycles later; early rvalid ignored.
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lw_hold_req", {31'b0, mem_req}, 32'd1);
            check("lw_hold_addr", mem_addr, 32'h0000_0200);
            check("lw_hold_be", {28'b0, mem_be}, 32'hF);
            check("lw_hold_stall", {31'b0, lsu_stall}, 32'd1);
            mem_rvalid = (i == 1);
            mem_rdata  = (i == 1) ? 32'hBAD0_BAD0 : 32'h0;
            mem_gnt    = (i == 3);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            mem_gnt = 1'b0;
            check("lw_wait_req", {31'b0, mem_req}, 32'd0);
            check("lw_wait_resp", {31'b0, resp_valid}, 32'd0);
            check("lw_wait_stall", {31'b0, lsu_stall}, 32'd1);
            mem_rvalid = (i == 1);
            mem_rdata  = (i == 1) ? 32'h1234_5678 : 32'h0;
        end
        tick();
        check("lw_resp", {31'b0, resp_valid}, 32'd1);
        check("lw_rdata", resp_rdata, 32'h1234_5678);
        check("lw_done_stall", {31'b0, lsu_stall}, 32'd0);
        release_req();
        tick();
        check("lw_single_pulse", {31'b0, resp_valid}, 32'd0);

        // LED MMIO store then load: no bus, resp on cycle 2.
        issue(1'b1, 3'b010, 32'hFFFF_FFF0, 32'h0000_000B);
        tick();
        check("led_sw_resp", {31'b0, resp_valid}, 32'd1);
        check("led_sw_req", {31'b0, mem_req}, 32'd0);
        check("led_sw_leds", {28'b0, leds}, 32'hB);
        check("led_sw_fault", {31'b0, lsu_fault}, 32'd0);
        release_req();
        tick();
        issue(1'b0, 3'b010, 32'hFFFF_FFF0, 32'h0);
        tick();
        check("led_lw_resp", {31'b0, resp_valid}, 32'd1);
        check("led_lw_req", {31'b0, mem_req}, 32'd0);
        check("led_lw_rdata", resp_rdata, 32'h0000_000B);
        release_req();
        tick();

        // Misaligned SH, misaligned LW, illegal funct3: fault on cycle 2, no bus, LEDs kept.
        issue(1'b1, 3'b001, 32'h0000_0101, 32'h0000_0005);
        tick();
        check("sh_mis_resp", {30'b0, resp_valid, lsu_fault}, 32'b11);
        check("sh_mis_req", {31'b0, mem_req}, 32'd0);
        check("sh_mis_leds", {28'b0, leds}, 32'hB);
        release_req();
        tick();
        check("sh_mis_fault_end", {31'b0, lsu_fault}, 32'd0);
        issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        tick();
        check("lw_mis_resp", {30'b0, resp_valid, lsu_fault}, 32'b11);
        check("lw_mis_rdata", resp_rdata, 32'd0);
        check("lw_mis_req", {31'b0, mem_req}, 32'd0);
        release_req();
        tick();
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        tick();
        check("f3_ill_resp", {30'b0, resp_valid, lsu_fault}, 32'b11);
        check("f3_ill_req", {31'b0, mem_req}, 32'd0);
        release_req();
        tick();

        // Reset while in WAIT: request dropped, late rvalid ignored.
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("rstw_in_wait", {31'b0, mem_req}, 32'd0);
        rst = 1'b1;
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rstw_req", {31'b0, mem_req}, 32'd0);
        check("rstw_leds", {28'b0, leds}, 32'd0);
        check("rstw_resp", {31'b0, resp_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        check("rstw_late_rvalid", {31'b0, resp_valid}, 32'd0);
        mem_rvalid = 1'b0;
        tick();
        check("rstw_late_rvalid2", {31'b0, resp_valid}, 32'd0);
        issue(1'b1, 3'b000, 32'hFFFF_FFF3, 32'h0000_0017);
        tick();
        check("rstw_idle_resp", {31'b0, resp_valid}, 32'd1);
        check("rstw_idle_leds", {28'b0, leds}, 32'h7);
        release_req();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
